// File: rtl/fir_ctrl_pkg.sv
// Shared control definitions for the FIR coefficient loader.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient register array with a single indexed write port.
module fir_coeff_bank #(
    parameter int unsigned N           = 4,
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned IDX_W       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [IDX_W-1:0]           widx,
    input  logic [COEFF_WIDTH-1:0]     wdata,
    output logic [N*COEFF_WIDTH-1:0]   bank
);

    logic [COEFF_WIDTH-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < N; t++) begin
                mem[t] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Flatten into the same tap layout as the active bank.
    always_comb begin
        bank = '0;
        for (int unsigned t = 0; t < N; t++) begin
            bank[COEFF_WIDTH*t +: COEFF_WIDTH] = mem[t];
        end
    end

endmodule

// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: beats fill a shadow bank, committed on sample_en.
// Optional tap readback port enabled by defining FIR_COEFF_READBACK_EN.
module fir_coeff_loader
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned                N            = 4,
    parameter int unsigned                COEFF_WIDTH  = 8,
    parameter logic [N*COEFF_WIDTH-1:0]   RESET_COEFFS = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          wr_valid,
    input  logic [COEFF_WIDTH-1:0]        wr_data,
    output logic                          wr_ready,
    input  logic                          sample_en,
    output logic [N*COEFF_WIDTH-1:0]      packed_coeffs,
    output logic                          busy,
    output logic                          done,
    output logic                          err
`ifdef FIR_COEFF_READBACK_EN
    ,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] rd_idx,
    output logic [COEFF_WIDTH-1:0]        rd_data
`endif
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t                   state, state_next;
    logic [IDX_W-1:0]         idx, idx_next;
    logic                     xfer;
    logic                     commit;
    logic                     err_next;
    logic [N*COEFF_WIDTH-1:0] shadow;

    fir_coeff_bank #(
        .N           (N),
        .COEFF_WIDTH (COEFF_WIDTH),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (xfer),
        .widx  (idx),
        .wdata (wr_data),
        .bank  (shadow)
    );

    // Next-state logic; abort wins over start, final beat and sample_en.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        xfer       = 1'b0;
        commit     = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    idx_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    err_next = start;
                    if (wr_valid && wr_ready) begin
                        xfer = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_next = PENDING;
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end
                end
            end
            PENDING: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    err_next = start;
                    if (sample_en) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            packed_coeffs <= RESET_COEFFS;
            wr_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            wr_ready <= (state_next == LOAD);
            busy     <= (state_next != IDLE);
            done     <= commit;
            err      <= err_next;
            if (commit) begin
                packed_coeffs <= shadow;
            end
        end
    end

`ifdef FIR_COEFF_READBACK_EN
    logic [COEFF_WIDTH-1:0] rd_mux_c;

    // Out-of-range indices fall through to zero.
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned t = 0; t < N; t++) begin
            if (32'(rd_idx) == t) begin
                rd_mux_c = packed_coeffs[COEFF_WIDTH*t +: COEFF_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux_c;
        end
    end
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: directed scenarios then random traffic vs. a queue model.
module tb_fir_coeff_loader;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam logic [31:0] RST_VAL = 32'hA5C3_0F96;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic          sample_en;
    logic [31:0]   packed_coeffs;
    logic          busy;
    logic          done;
    logic          err;
`ifdef FIR_COEFF_READBACK_EN
    logic [1:0]    rd_idx;
    logic [W-1:0]  rd_data;
`endif

    fir_coeff_loader #(
        .N            (N),
        .COEFF_WIDTH  (W),
        .RESET_COEFFS (RST_VAL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .sample_en     (sample_en),
        .packed_coeffs (packed_coeffs),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef FIR_COEFF_READBACK_EN
        ,
        .rd_idx        (rd_idx),
        .rd_data       (rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: 0 = idle, 1 = collecting beats, 2 = waiting for sample.
    int          m_mode;
    logic [W-1:0] m_beats[$];
    logic [31:0] m_active;
    logic        m_done;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic a,
                              input logic v, input logic [W-1:0] d, input logic se);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!r) begin
            m_mode = 0;
            m_beats.delete();
            m_active = RST_VAL;
        end else if (m_mode == 0) begin
            if (s && !a) begin
                m_mode = 1;
                m_beats.delete();
            end
        end else if (a) begin
            m_mode = 0;
        end else begin
            m_err = s;
            if (m_mode == 1 && v) begin
                m_beats.push_back(d);
                if (m_beats.size() == N) m_mode = 2;
            end else if (m_mode == 2 && se) begin
                for (int t = 0; t < int'(N); t++) m_active[W*t +: W] = m_beats[t];
                m_done = 1'b1;
                m_mode = 0;
            end
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT, then compare all outputs.
    task automatic step(input string tag, input logic r, input logic s, input logic a,
                        input logic v, input logic [W-1:0] d, input logic se);
        rst_n = r; start = s; abort = a; wr_valid = v; wr_data = d; sample_en = se;
        model_edge(r, s, a, v, d, se);
        @(posedge clk);
        #1;
        check({tag, ".coeffs"}, packed_coeffs, m_active);
        check({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
        check({tag, ".ready"}, 32'(wr_ready), 32'(m_mode == 1));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic beat(input string tag, input logic [W-1:0] d);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        m_mode = 0; m_active = RST_VAL; m_done = 0; m_err = 0;
        rst_n = 0; start = 0; abort = 0; wr_valid = 0; wr_data = '0; sample_en = 0;
`ifdef FIR_COEFF_READBACK_EN
        rd_idx = '0;
`endif
        #1;
        step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step("rst1", 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        check("rst_val", packed_coeffs, RST_VAL);

        // Basic load of 1,2,3,4 and commit three cycles later.
        step("start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) beat("b", 8'(i));
        idle("p0"); idle("p1");
        step("commit", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("basic_val", packed_coeffs, 32'h0403_0201);
        check("basic_done", 32'(done), 32'd1);
        idle("post");
        check("basic_busy", 32'(busy), 32'd0);

        // Gapped beats with sample_en during LOAD.
        step("g_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        beat("g0", 8'h11);
        step("g_gap0", 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
        beat("g1", 8'h22);
        step("g_gap1", 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
        beat("g2", 8'h33);
        step("g3", 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
        check("gap_hold", packed_coeffs, 32'h0403_0201);
        step("g_commit", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("gap_val", packed_coeffs, 32'h4433_2211);

        // Abort collides with final beat.
        step("a_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        beat("a0", 8'h99); beat("a1", 8'h98); beat("a2", 8'h97);
        step("a3", 1'b1, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0);
        check("abort_idle", 32'(busy), 32'd0);
        step("a_se", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("abort_keep", packed_coeffs, 32'h4433_2211);

        // Abort in PENDING beats sample_en; start+abort is abort only.
        step("ap_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) beat("ap", 8'h70 + 8'(i));
        step("ap_abort", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        check("ap_keep", packed_coeffs, 32'h4433_2211);

        // start during LOAD flags err and the load continues.
        step("e_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        beat("e0", 8'hA1);
        step("e_dup", 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0);
        check("err_pulse", 32'(err), 32'd1);
        beat("e2", 8'hA3); beat("e3", 8'hA4);
        step("e_commit", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("err_val", packed_coeffs, 32'hA4A3_A2A1);

`ifdef FIR_COEFF_READBACK_EN
        step("rb_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) beat("rb", 8'(i));
        step("rb_commit", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            idle("rb_rd");
            check("rd_data", 32'(rd_data), 32'(i + 1));
        end
`endif

        // Reset in the middle of a load.
        step("r_start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        beat("r0", 8'h5A); beat("r1", 8'h5B);
        step("r_rst", 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b0);
        check("midrst_val", packed_coeffs, RST_VAL);
        check("midrst_busy", 32'(busy), 32'd0);
        idle("r_after");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step("rnd",
                 ($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 55),
                 8'($urandom),
                 ($urandom_range(0, 99) < 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
